// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage types: FSM states, default widths and the
// MEM/WB bubble encoding.
package mem_access_stage_pkg;

   localparam int MEM_DATA_WIDTH     = 32;
   localparam int MEM_REG_ADDR_WIDTH = 5;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } state_e;

   typedef struct packed {
      logic reg_wr_en;
      logic mem_to_reg_wr;
   } wb_ctrl_t;

   localparam wb_ctrl_t WB_BUBBLE = '{reg_wr_en: 1'b0, mem_to_reg_wr: 1'b0};

endpackage

// File: rtl/d_ff.sv
// Enabled pipeline register with synchronous active-low clear.
module d_ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_access_stage_sat_counter.sv
// Enable counter that sticks at all-ones instead of wrapping.
module mem_access_stage_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the valid/ready data-memory port, stalls upstream
// while an access is outstanding and builds the MEM/WB register.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int DATA_WIDTH     = MEM_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = MEM_REG_ADDR_WIDTH,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ex_mem_reg_wr_en,
   input  logic                      ex_mem_mem_to_reg_wr,
   input  logic                      ex_mem_mem_wr_en,
   input  logic [REG_ADDR_WIDTH-1:0] ex_mem_reg_wr_addr,
   input  logic [DATA_WIDTH-1:0]     ex_mem_alu_result,
   input  logic [DATA_WIDTH-1:0]     ex_mem_mem_wr_data,
   output logic                      dmem_req_valid,
   input  logic                      dmem_req_ready,
   output logic                      dmem_req_we,
   output logic [DATA_WIDTH-1:0]     dmem_req_addr,
   output logic [DATA_WIDTH-1:0]     dmem_req_wdata,
   input  logic                      dmem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]     dmem_rsp_rdata,
   output logic                      mem_stall,
   output logic [DATA_WIDTH-1:0]     mem_fwd_data,
   output logic                      mem_wb_reg_wr_en,
   output logic                      mem_wb_mem_to_reg_wr,
   output logic [REG_ADDR_WIDTH-1:0] mem_wb_reg_wr_addr,
   output logic [DATA_WIDTH-1:0]     mem_wb_alu_result,
   output logic [DATA_WIDTH-1:0]     mem_wb_read_data,
   output logic                      mem_misaligned,
   output logic [CNT_WIDTH-1:0]      stall_count
);

   state_e   state;
   state_e   state_d;
   wb_ctrl_t wb_ctrl_d;
   logic     access;
   logic     is_store;
   logic     aligned;
   logic     rd_capture;
   logic     misaligned_d;

   assign dmem_req_we    = ex_mem_mem_wr_en;
   assign dmem_req_addr  = ex_mem_alu_result;
   assign dmem_req_wdata = ex_mem_mem_wr_data;
   assign mem_fwd_data   = ex_mem_alu_result;

   always_comb begin
      access         = ex_mem_mem_to_reg_wr | ex_mem_mem_wr_en;
      is_store       = ex_mem_mem_wr_en;
      aligned        = (ex_mem_alu_result[1:0] == 2'b00);
      dmem_req_valid = 1'b0;
      mem_stall      = 1'b0;
      rd_capture     = 1'b0;
      misaligned_d   = 1'b0;
      state_d        = state;
      wb_ctrl_d      = '{reg_wr_en:     ex_mem_reg_wr_en,
                         mem_to_reg_wr: ex_mem_mem_to_reg_wr};
      unique case (state)
         IDLE: begin
            if (access && !aligned) begin
               wb_ctrl_d    = WB_BUBBLE;
               misaligned_d = 1'b1;
            end else if (access) begin
               dmem_req_valid = 1'b1;
               if (!dmem_req_ready) begin
                  mem_stall = 1'b1;
                  wb_ctrl_d = WB_BUBBLE;
               end else if (is_store) begin
                  wb_ctrl_d.reg_wr_en = 1'b0;
               end else if (dmem_rsp_valid) begin
                  rd_capture = 1'b1;
               end else begin
                  mem_stall = 1'b1;
                  wb_ctrl_d = WB_BUBBLE;
                  state_d   = WAIT_RSP;
               end
            end
         end
         WAIT_RSP: begin
            if (dmem_rsp_valid) begin
               rd_capture = 1'b1;
               state_d    = IDLE;
            end else begin
               mem_stall = 1'b1;
               wb_ctrl_d = WB_BUBBLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   d_ff #(.WIDTH(1)) u_wb_reg_wr_en (
      .clk(clk), .reset(reset), .en(1'b1),
      .d(wb_ctrl_d.reg_wr_en), .q(mem_wb_reg_wr_en)
   );

   d_ff #(.WIDTH(1)) u_wb_mem_to_reg (
      .clk(clk), .reset(reset), .en(1'b1),
      .d(wb_ctrl_d.mem_to_reg_wr), .q(mem_wb_mem_to_reg_wr)
   );

   d_ff #(.WIDTH(REG_ADDR_WIDTH)) u_wb_reg_wr_addr (
      .clk(clk), .reset(reset), .en(1'b1),
      .d(ex_mem_reg_wr_addr), .q(mem_wb_reg_wr_addr)
   );

   d_ff #(.WIDTH(DATA_WIDTH)) u_wb_alu_result (
      .clk(clk), .reset(reset), .en(1'b1),
      .d(ex_mem_alu_result), .q(mem_wb_alu_result)
   );

   // Load data only moves when a read actually completes.
   d_ff #(.WIDTH(DATA_WIDTH)) u_wb_read_data (
      .clk(clk), .reset(reset), .en(rd_capture),
      .d(dmem_rsp_rdata), .q(mem_wb_read_data)
   );

   d_ff #(.WIDTH(1)) u_misaligned (
      .clk(clk), .reset(reset), .en(1'b1),
      .d(misaligned_d), .q(mem_misaligned)
   );

   mem_access_stage_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk(clk), .reset(reset), .en(mem_stall), .count(stall_count)
   );

endmodule

// File: tb/tb_mem_access_stage.sv
// Transaction-level randomized bench for the MEM stage.
module tb_mem_access_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ex_mem_reg_wr_en = 1'b0;
   logic          ex_mem_mem_to_reg_wr = 1'b0;
   logic          ex_mem_mem_wr_en = 1'b0;
   logic [AW-1:0] ex_mem_reg_wr_addr = '0;
   logic [DW-1:0] ex_mem_alu_result = '0;
   logic [DW-1:0] ex_mem_mem_wr_data = '0;
   logic          dmem_req_valid;
   logic          dmem_req_ready = 1'b0;
   logic          dmem_req_we;
   logic [DW-1:0] dmem_req_addr;
   logic [DW-1:0] dmem_req_wdata;
   logic          dmem_rsp_valid = 1'b0;
   logic [DW-1:0] dmem_rsp_rdata = '0;
   logic          mem_stall;
   logic [DW-1:0] mem_fwd_data;
   logic          mem_wb_reg_wr_en;
   logic          mem_wb_mem_to_reg_wr;
   logic [AW-1:0] mem_wb_reg_wr_addr;
   logic [DW-1:0] mem_wb_alu_result;
   logic [DW-1:0] mem_wb_read_data;
   logic          mem_misaligned;
   logic [CW-1:0] stall_count;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_rd = '0;
   int unsigned exp_cnt = 0;

   always #5 clk = ~clk;

   mem_access_stage #(
      .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ex_mem_reg_wr_en(ex_mem_reg_wr_en),
      .ex_mem_mem_to_reg_wr(ex_mem_mem_to_reg_wr),
      .ex_mem_mem_wr_en(ex_mem_mem_wr_en),
      .ex_mem_reg_wr_addr(ex_mem_reg_wr_addr),
      .ex_mem_alu_result(ex_mem_alu_result),
      .ex_mem_mem_wr_data(ex_mem_mem_wr_data),
      .dmem_req_valid(dmem_req_valid),
      .dmem_req_ready(dmem_req_ready),
      .dmem_req_we(dmem_req_we),
      .dmem_req_addr(dmem_req_addr),
      .dmem_req_wdata(dmem_req_wdata),
      .dmem_rsp_valid(dmem_rsp_valid),
      .dmem_rsp_rdata(dmem_rsp_rdata),
      .mem_stall(mem_stall),
      .mem_fwd_data(mem_fwd_data),
      .mem_wb_reg_wr_en(mem_wb_reg_wr_en),
      .mem_wb_mem_to_reg_wr(mem_wb_mem_to_reg_wr),
      .mem_wb_reg_wr_addr(mem_wb_reg_wr_addr),
      .mem_wb_alu_result(mem_wb_alu_result),
      .mem_wb_read_data(mem_wb_read_data),
      .mem_misaligned(mem_misaligned),
      .stall_count(stall_count)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock of memory-side stimulus with the combinational checks.
   task automatic cyc(input logic rdy, input logic rv,
                      input logic [DW-1:0] rd,
                      input logic e_valid, input logic e_stall);
      @(negedge clk);
      dmem_req_ready = rdy;
      dmem_rsp_valid = rv;
      dmem_rsp_rdata = rd;
      #1;
      chk("req_valid", 64'(dmem_req_valid), 64'(e_valid));
      chk("stall", 64'(mem_stall), 64'(e_stall));
      chk("fwd", 64'(mem_fwd_data), 64'(ex_mem_alu_result));
      if (e_valid) begin
         chk("req_we", 64'(dmem_req_we), 64'(ex_mem_mem_wr_en));
         chk("req_addr", 64'(dmem_req_addr), 64'(ex_mem_alu_result));
         chk("req_wdata", 64'(dmem_req_wdata), 64'(ex_mem_mem_wr_data));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bubble();
      chk("bub_wr_en", 64'(mem_wb_reg_wr_en), 64'd0);
      chk("bub_mtr", 64'(mem_wb_mem_to_reg_wr), 64'd0);
      chk("bub_mis", 64'(mem_misaligned), 64'd0);
      chk("bub_rd", 64'(mem_wb_read_data), 64'(exp_rd));
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // kind: 0 = ALU op, 1 = load, 2 = store. nr = ready-low cycles,
   // nrsp = cycles from accepted read to response.
   task automatic run(input int kind, input logic both,
                      input logic [DW-1:0] a, input logic [DW-1:0] wd,
                      input logic wr, input logic [AW-1:0] ra,
                      input int nr, input int nrsp,
                      input logic [DW-1:0] rdata);
      logic mis;
      mis = (kind != 0) && (a[1:0] != 2'b00);
      ex_mem_reg_wr_en     = wr;
      ex_mem_mem_to_reg_wr = (kind == 1) || (kind == 2 && both);
      ex_mem_mem_wr_en     = (kind == 2);
      ex_mem_reg_wr_addr   = ra;
      ex_mem_alu_result    = a;
      ex_mem_mem_wr_data   = wd;
      if (kind == 0 || mis) begin
         cyc(rbit(), rbit(), $urandom, 1'b0, 1'b0);
         chk("wr_en", 64'(mem_wb_reg_wr_en), mis ? 64'd0 : 64'(wr));
         chk("mtr", 64'(mem_wb_mem_to_reg_wr), 64'd0);
         chk("mis", 64'(mem_misaligned), 64'(mis));
         chk("rd_hold", 64'(mem_wb_read_data), 64'(exp_rd));
         if (!mis) begin
            chk("alu", 64'(mem_wb_alu_result), 64'(a));
            chk("wb_addr", 64'(mem_wb_reg_wr_addr), 64'(ra));
         end
      end else begin
         repeat (nr) begin
            cyc(1'b0, rbit(), $urandom, 1'b1, 1'b1);
            chk_bubble();
            exp_cnt++;
         end
         if (kind == 2) begin
            cyc(1'b1, rbit(), $urandom, 1'b1, 1'b0);
            chk("st_wr_en", 64'(mem_wb_reg_wr_en), 64'd0);
            chk("st_mtr", 64'(mem_wb_mem_to_reg_wr), 64'(both));
            chk("st_rd", 64'(mem_wb_read_data), 64'(exp_rd));
         end else begin
            if (nrsp == 0) begin
               cyc(1'b1, 1'b1, rdata, 1'b1, 1'b0);
            end else begin
               cyc(1'b1, 1'b0, $urandom, 1'b1, 1'b1);
               chk_bubble();
               exp_cnt++;
               repeat (nrsp - 1) begin
                  cyc(rbit(), 1'b0, $urandom, 1'b0, 1'b1);
                  chk_bubble();
                  exp_cnt++;
               end
               cyc(rbit(), 1'b1, rdata, 1'b0, 1'b0);
            end
            exp_rd = rdata;
            chk("ld_wr_en", 64'(mem_wb_reg_wr_en), 64'(wr));
            chk("ld_mtr", 64'(mem_wb_mem_to_reg_wr), 64'd1);
            chk("ld_rd", 64'(mem_wb_read_data), 64'(rdata));
         end
         chk("mem_alu", 64'(mem_wb_alu_result), 64'(a));
         chk("mem_addr", 64'(mem_wb_reg_wr_addr), 64'(ra));
         chk("mem_mis", 64'(mem_misaligned), 64'd0);
      end
      chk("stall_count", 64'(stall_count), 64'(exp_cnt));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wr_en"}, 64'(mem_wb_reg_wr_en), 64'd0);
      chk({tag, "_mtr"}, 64'(mem_wb_mem_to_reg_wr), 64'd0);
      chk({tag, "_addr"}, 64'(mem_wb_reg_wr_addr), 64'd0);
      chk({tag, "_alu"}, 64'(mem_wb_alu_result), 64'd0);
      chk({tag, "_rd"}, 64'(mem_wb_read_data), 64'd0);
      chk({tag, "_mis"}, 64'(mem_misaligned), 64'd0);
      chk({tag, "_cnt"}, 64'(stall_count), 64'd0);
   endtask

   initial begin
      int kind;
      logic [DW-1:0] a;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("rst");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      run(0, 1'b0, 32'h1234, 32'h0, 1'b1, 5'd5, 0, 0, 32'h0);
      run(2, 1'b0, 32'h40, 32'hDEADBEEF, 1'b1, 5'd9, 0, 0, 32'h0);
      run(1, 1'b0, 32'h80, 32'h0, 1'b1, 5'd7, 0, 3, 32'hCAFEF00D);
      chk("stall3", 64'(stall_count), 64'd3);
      run(2, 1'b0, 32'h44, 32'h01234567, 1'b0, 5'd2, 2, 0, 32'h0);
      chk("stall5", 64'(stall_count), 64'd5);
      run(1, 1'b0, 32'h42, 32'h0, 1'b1, 5'd4, 0, 0, 32'h0);
      run(0, 1'b0, 32'h99, 32'h0, 1'b1, 5'd1, 0, 0, 32'h0);

      // Reset while a read is outstanding, then a stray response.
      ex_mem_reg_wr_en     = 1'b1;
      ex_mem_mem_to_reg_wr = 1'b1;
      ex_mem_mem_wr_en     = 1'b0;
      ex_mem_reg_wr_addr   = 5'd3;
      ex_mem_alu_result    = 32'h100;
      cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      chk_bubble();
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_bubble();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk_all_zero("mid_rst");
      @(negedge clk);
      reset                = 1'b1;
      ex_mem_mem_to_reg_wr = 1'b0;
      ex_mem_reg_wr_en     = 1'b0;
      dmem_rsp_valid       = 1'b1;
      dmem_rsp_rdata       = 32'h5A5A5A5A;
      exp_cnt = 0;
      exp_rd  = '0;
      cyc(1'b0, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b0);
      chk("stray_rd", 64'(mem_wb_read_data), 64'd0);
      chk("stray_cnt", 64'(stall_count), 64'd0);
      chk("stray_wr", 64'(mem_wb_reg_wr_en), 64'd0);

      for (int i = 0; i < 400; i++) begin
         kind = int'($urandom_range(0, 2));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run(kind, rbit(), a, $urandom, rbit(), AW'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
             $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
